// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package muldiv_pkg;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam int ITER_CNT = 32;
endpackage

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Works on magnitudes one bit per cycle and fixes signs in a final cycle.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             hilo_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hilo_out
);
  localparam int CW = 6;

  logic [1:0]         state;
  logic [1:0]         op_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  // shf: bits consumed MSB-first (multiplier or dividend)
  // opd: the other magnitude (multiplicand or divisor)
  logic [WIDTH-1:0]   shf, opd, a_raw;
  logic               neg_p, neg_q, neg_r, div_zero;
  logic [WIDTH:0]     trial;
  logic               is_signed, is_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_signed = op[0];
  assign is_div    = op_q[1];
  assign abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;
  assign busy      = (state != ST_IDLE);
  assign hilo_out  = hilo_sel ? hi : lo;

  assign prod_fix = neg_p ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // One iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    acc_nxt = acc;
    trial   = {acc[2*WIDTH-1:WIDTH], shf[WIDTH-1]} - {1'b0, opd};
    if (!is_div) begin
      acc_nxt = {acc[2*WIDTH-2:0], 1'b0} + (shf[WIDTH-1] ? {{WIDTH{1'b0}}, opd} : '0);
    end else if (!trial[WIDTH]) begin
      acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {acc[2*WIDTH-2:WIDTH], shf[WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, operand latch and iteration datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      cnt      <= '0;
      acc      <= '0;
      shf      <= '0;
      opd      <= '0;
      a_raw    <= '0;
      neg_p    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state    <= ST_CALC;
          op_q     <= op;
          cnt      <= '0;
          acc      <= '0;
          shf      <= op[1] ? abs_a : abs_b;
          opd      <= op[1] ? abs_b : abs_a;
          a_raw    <= a;
          neg_p    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_q    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r    <= is_signed && a[WIDTH-1];
          div_zero <= (b == '0);
        end
        ST_CALC: begin
          acc <= acc_nxt;
          shf <= {shf[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER_CNT - 1)) state <= ST_FIX;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // HI/LO: MTHI/MTLO only while idle, results land in the FIX cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == ST_FIX);
      if (state == ST_IDLE) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end else if (state == ST_FIX) begin
        if (!is_div) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
          hi <= a_raw;
          lo <= '1;
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end
    end
  end
endmodule
